regfile_wb_arbiter: RTL and testbench

Two-requester arbiter for the register-file write port of the MIPS datapath. The ALU write-back path (requester 0) and the load-return path (requester 1) compete for the single write port. The block grants one requester per cycle using round-robin priority and registers the winning destination address and data onto the port. It sits between the execute/memory stages and the register file, and owns the selection of the 5-bit destination address.

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port.
// Requester 0 is the ALU write-back path and requester 1 is the load-return path.
// The winner's address and data are registered onto the RF_* outputs one cycle
// after acceptance. Writes to register 0 complete the handshake, but RF_WrEn
// stays low for them.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req0_Valid,
  input  logic [ADDR_WIDTH-1:0] Req0_Addr,
  input  logic [DATA_WIDTH-1:0] Req0_Data,
  output logic                  Req0_Ready,
  input  logic                  Req1_Valid,
  input  logic [ADDR_WIDTH-1:0] Req1_Addr,
  input  logic [DATA_WIDTH-1:0] Req1_Data,
  output logic                  Req1_Ready,
  output logic                  RF_WrEn,
  output logic [ADDR_WIDTH-1:0] RF_WrAddr,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  Wr_Src,
  output logic [CNT_WIDTH-1:0]  Conflict_Count
);

  // Index of the most recently granted requester. It resets to 1 so that
  // requester 0 wins the first conflict.
  logic                  last_grant_q, last_grant_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_src_q, wr_src_d;
  logic [CNT_WIDTH-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic                  grant_0;
  logic                  grant_1;
  logic                  both_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign both_valid = Req0_Valid & Req1_Valid;

  // Combinational grant: a sole requester wins; under contention the one not granted last wins
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (both_valid) begin
      if (last_grant_q) begin
        grant_0 = 1'b1;
      end else begin
        grant_1 = 1'b1;
      end
    end else begin
      grant_0 = Req0_Valid;
      grant_1 = Req1_Valid;
    end
  end

  // Ready is masked while Reset is high, so nothing is accepted during reset
  assign Req0_Ready = grant_0 & ~Reset;
  assign Req1_Ready = grant_1 & ~Reset;

  // Mux the winning requester's payload toward the output stage
  always_comb begin
    sel_addr = Req0_Addr;
    sel_data = Req0_Data;
    if (grant_1) begin
      sel_addr = Req1_Addr;
      sel_data = Req1_Data;
    end
  end

  // Next-state: load the output stage on a grant, hold it otherwise; saturate the conflict counter
  always_comb begin
    last_grant_d   = last_grant_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    wr_src_d       = wr_src_q;
    conflict_cnt_d = conflict_cnt_q;

    if (grant_0 || grant_1) begin
      last_grant_d = grant_1;
      wr_en_d      = (sel_addr != '0);
      wr_addr_d    = sel_addr;
      wr_data_d    = sel_data;
      wr_src_d     = grant_1;
    end

    if (both_valid && (conflict_cnt_q != {CNT_WIDTH{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers with immediate clear on Reset; this cancels any pending registered write
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_grant_q   <= 1'b1;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_src_q       <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_src_q       <= wr_src_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign RF_WrEn        = wr_en_q;
  assign RF_WrAddr      = wr_addr_q;
  assign RF_WrData      = wr_data_q;
  assign Wr_Src         = wr_src_q;
  assign Conflict_Count = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. It runs the directed scenarios
// first, then randomized requester traffic. A behavioural model tracks the
// expected port contents. Each requester holds its request until it is accepted.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req0_Valid = 1'b0;
  logic [4:0]  Req0_Addr = '0;
  logic [31:0] Req0_Data = '0;
  logic        Req0_Ready;
  logic        Req1_Valid = 1'b0;
  logic [4:0]  Req1_Addr = '0;
  logic [31:0] Req1_Data = '0;
  logic        Req1_Ready;
  logic        RF_WrEn;
  logic [4:0]  RF_WrAddr;
  logic [31:0] RF_WrData;
  logic        Wr_Src;
  logic [7:0]  Conflict_Count;

  regfile_wb_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .CNT_WIDTH(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Req0_Valid(Req0_Valid),
    .Req0_Addr(Req0_Addr),
    .Req0_Data(Req0_Data),
    .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid),
    .Req1_Addr(Req1_Addr),
    .Req1_Data(Req1_Data),
    .Req1_Ready(Req1_Ready),
    .RF_WrEn(RF_WrEn),
    .RF_WrAddr(RF_WrAddr),
    .RF_WrData(RF_WrData),
    .Wr_Src(Wr_Src),
    .Conflict_Count(Conflict_Count)
  );

  always #5 Clk = ~Clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model of what the register-file port should show.
  int          m_last;   // requester granted most recently
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_src;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Return the winner under round-robin rules (-1 if nobody requests)
  function automatic int model_grant();
    if (Req0_Valid && Req1_Valid) return (m_last == 0) ? 1 : 0;
    if (Req0_Valid) return 0;
    if (Req1_Valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_src  = 0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs(input string phase);
    check({phase, ".wren"},  RF_WrEn,        m_wen);
    check({phase, ".waddr"}, RF_WrAddr,      m_addr);
    check({phase, ".wdata"}, RF_WrData,      m_data);
    check({phase, ".src"},   Wr_Src,         m_src[0]);
    check({phase, ".cnt"},   Conflict_Count, m_cnt[7:0]);
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1
  task automatic step(output int g);
    logic both;
    g = model_grant();
    both = Req0_Valid && Req1_Valid;
    #1;
    check("ready0", Req0_Ready, (g == 0));
    check("ready1", Req1_Ready, (g == 1));
    @(posedge Clk);
    if (g >= 0) begin
      m_addr = (g == 0) ? Req0_Addr : Req1_Addr;
      m_data = (g == 0) ? Req0_Data : Req1_Data;
      m_src  = g;
      m_wen  = (m_addr != 0);
      m_last = g;
    end else begin
      m_wen = 1'b0;
    end
    if (both && m_cnt < 255) m_cnt++;
    #1;
    check_outputs("cyc");
    if (g >= 0)
      $display("[TB] write src=%0d addr=%0d data=0x%08h wren=%0b cnt=%0d",
               g, m_addr, m_data, m_wen, m_cnt);
  endtask

  // Assert Reset mid-cycle, check the immediate clear, then release just after a rising edge
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst.ready0", Req0_Ready, 1'b0);
    check("rst.ready1", Req1_Ready, 1'b0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    $display("[TB] reset released");
  endtask

  initial begin
    int g;
    model_reset();
    #2;

    // Reset then idle
    do_reset();
    for (int i = 0; i < 5; i++) step(g);

    // Single ALU write
    Req0_Valid = 1'b1; Req0_Addr = 5'd8; Req0_Data = 32'hDEADBEEF;
    step(g);
    Req0_Valid = 1'b0;
    check("alu.wren", RF_WrEn, 1'b1);
    check("alu.data", RF_WrData, 32'hDEADBEEF);
    step(g);

    // Contention from reset: requester 0 first, then 1
    do_reset();
    Req0_Valid = 1'b1; Req0_Addr = 5'd3; Req0_Data = 32'h0000_0003;
    Req1_Valid = 1'b1; Req1_Addr = 5'd4; Req1_Data = 32'h0000_0004;
    step(g);
    check("cont.first_addr", RF_WrAddr, 5'd3);
    if (g == 0) Req0_Valid = 1'b0;
    if (g == 1) Req1_Valid = 1'b0;
    step(g);
    check("cont.second_addr", RF_WrAddr, 5'd4);
    check("cont.cnt", Conflict_Count, 8'd1);
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    step(g);

    // Continuous contention: alternating sources
    do_reset();
    Req0_Valid = 1'b1; Req0_Addr = 5'd10; Req0_Data = $urandom;
    Req1_Valid = 1'b1; Req1_Addr = 5'd11; Req1_Data = $urandom;
    for (int i = 0; i < 6; i++) begin
      step(g);
      check("alt.src", Wr_Src, i[0]);
      if (g == 0) Req0_Data = $urandom;
      if (g == 1) Req1_Data = $urandom;
    end
    check("alt.cnt", Conflict_Count, 8'd6);
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    step(g);

    // Write to $zero: handshake completes, no write enable
    Req1_Valid = 1'b1; Req1_Addr = 5'd0; Req1_Data = 32'h1234;
    step(g);
    Req1_Valid = 1'b0;
    check("zero.wren", RF_WrEn, 1'b0);
    check("zero.src", Wr_Src, 1'b1);
    check("zero.data", RF_WrData, 32'h1234);

    // Saturation, then reset while a write is on the port
    do_reset();
    Req0_Valid = 1'b1; Req0_Addr = 5'd7;  Req0_Data = $urandom;
    Req1_Valid = 1'b1; Req1_Addr = 5'd9;  Req1_Data = $urandom;
    for (int i = 0; i < 300; i++) begin
      step(g);
      if (g == 0) Req0_Data = $urandom;
      if (g == 1) Req1_Data = $urandom;
    end
    check("sat.cnt", Conflict_Count, 8'd255);
    check("sat.wren_before_rst", RF_WrEn, 1'b1);
    do_reset();
    step(g);
    check("postrst.src", Wr_Src, 1'b0);

    // Randomized traffic, including $zero targets and occasional resets
    for (int i = 0; i < 600; i++) begin
      if (!Req0_Valid && ($urandom_range(0, 1) == 1)) begin
        Req0_Valid = 1'b1; Req0_Addr = 5'($urandom_range(0, 31)); Req0_Data = $urandom;
      end
      if (!Req1_Valid && ($urandom_range(0, 1) == 1)) begin
        Req1_Valid = 1'b1; Req1_Addr = 5'($urandom_range(0, 31)); Req1_Data = $urandom;
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(g);
        if (g == 0) Req0_Valid = 1'b0;
        if (g == 1) Req1_Valid = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
